aes_round_controller: RTL and testbench



---
 rtl/aes_round_controller.sv | 197 +++++++++++++++++++
 tb/tb_aes_round_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_controller.sv
// aes_round_controller: iterative AES-128 encryption controller.
// Owns the 128-bit state register, the round-key register, the round counter and
// Rcon generation. One round is computed per clock by the combinational round
// datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey, key-expansion step).
// Byte 0 is [127:120]; the layout is column-major, so column 0 is [127:96].
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   plaintext/key offered
//   in_ready   out  controller can accept a block (IDLE)
//   plaintext  in   128-bit input block
//   key        in   128-bit cipher key
//   abort      in   (only with AES_ROUND_CONTROLLER_ABORT_EN) drop the block in flight
//   out_valid  out  ciphertext available (DONE)
//   out_ready  in   consumer accepts ciphertext
//   ciphertext out  result, valid only while out_valid=1
//   busy       out  high while rounds are running
//   round_idx  out  current round number, 0 in IDLE/DONE
//
// Optional feature macro: AES_ROUND_CONTROLLER_ABORT_EN adds the abort input.
module aes_round_controller #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
`ifdef AES_ROUND_CONTROLLER_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  localparam logic [2047:0] Sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return Sbox[8 * (255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Row r of the column-major state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
      o[127 - 8 * i -: 8] = s[127 - 8 * src -: 8];
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  // One key-schedule step: next round key from the current one and Rcon.
  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e         r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [7:0]   r_rcon, w_rcon_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [127:0] r_ct, w_ct_nxt;

  logic [127:0] w_shift, w_round_key, w_round_out;
  logic         w_last, w_abort;

`ifdef AES_ROUND_CONTROLLER_ABORT_EN
  assign w_abort = abort && (r_fsm != StIdle);
`else
  assign w_abort = 1'b0;
`endif

  assign w_shift     = shift_rows(sub_bytes(r_state));
  assign w_round_key = expand_key(r_key, r_rcon);
  assign w_last      = (r_round == LastRound);
  // Final round skips MixColumns.
  assign w_round_out = (w_last ? w_shift : mix_columns(w_shift)) ^ w_round_key;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_rcon_nxt  = r_rcon;
    w_round_nxt = r_round;
    w_ct_nxt    = r_ct;
    if (w_abort) begin
      // Datapath registers and ciphertext keep their values on abort.
      w_fsm_nxt   = StIdle;
      w_round_nxt = 4'd0;
    end else begin
      unique case (r_fsm)
        StIdle: begin
          if (in_valid) begin
            w_state_nxt = plaintext ^ key;
            w_key_nxt   = key;
            w_rcon_nxt  = 8'h01;
            w_round_nxt = 4'd1;
            w_fsm_nxt   = StRound;
          end
        end
        StRound: begin
          w_state_nxt = w_round_out;
          w_key_nxt   = w_round_key;
          w_rcon_nxt  = xtime(r_rcon);
          if (w_last) begin
            w_ct_nxt    = w_round_out;
            w_round_nxt = 4'd0;
            w_fsm_nxt   = StDone;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
        StDone: begin
          if (out_ready) w_fsm_nxt = StIdle;
        end
        default: w_fsm_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_key   <= '0;
      r_rcon  <= '0;
      r_round <= '0;
      r_ct    <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_rcon  <= w_rcon_nxt;
      r_round <= w_round_nxt;
      r_ct    <= w_ct_nxt;
    end
  end

  assign in_ready   = (r_fsm == StIdle);
  assign busy       = (r_fsm == StRound);
  assign out_valid  = (r_fsm == StDone);
  assign round_idx  = r_round;
  assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller with known-answer AES-128 vectors.
module tb_aes_round_controller;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] plaintext, key, ciphertext;
  logic [3:0]   round_idx;
`ifdef AES_ROUND_CONTROLLER_ABORT_EN
  logic         abort;
`endif

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs[3];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc, at, j, k;
  int   acc3[3];
  bit   seen;

  aes_round_controller #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .plaintext (plaintext),
    .key       (key),
`ifdef AES_ROUND_CONTROLLER_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ciphertext(ciphertext),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer a block as soon as the controller is idle; acc_o is the accept cycle.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] k_in,
                             output int acc_o);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("idle in_ready", {127'b0, in_ready}, 128'd1);
    plaintext = pt;
    key       = k_in;
    in_valid  = 1'b1;
    acc_o     = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    check("accept {in_ready,busy}", {126'b0, in_ready, busy}, 128'b01);
    check("accept round_idx", {124'b0, round_idx}, 128'd1);
  endtask

  task automatic wait_valid(output int at_o);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("out_valid seen", {127'b0, out_valid}, 128'd1);
    at_o = cyc;
  endtask

  task automatic wait_round(input logic [3:0] target);
    for (int i = 0; i < 20 && round_idx != target; i++) @(negedge clk);
    check("reach round", {124'b0, round_idx}, {124'b0, target});
  endtask

  task automatic run_block(input vec_t v, input string name);
    int a0, a1;
    start_block(v.pt, v.key, a0);
    wait_valid(a1);
    check({name, " latency"}, 128'(a1 - a0), 128'd11);
    check({name, " ciphertext"}, ciphertext, v.ct);
    check({name, " done {in_ready,busy,round_idx}"},
          {122'b0, in_ready, busy, round_idx}, 128'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " release {out_valid,in_ready}"}, {126'b0, out_valid, in_ready}, 128'b01);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
`ifdef AES_ROUND_CONTROLLER_ABORT_EN
    abort = 1'b0;
`endif
    vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    repeat (2) @(negedge clk);
    check("reset {in_ready,out_valid,busy}", {125'b0, in_ready, out_valid, busy}, 128'b100);
    check("reset round_idx", {124'b0, round_idx}, 128'd0);
    check("reset ciphertext", ciphertext, 128'd0);
    rst = 1'b0;

    // Table of known-answer vectors.
    for (int v = 0; v < 3; v++) run_block(vecs[v], $sformatf("vec%0d", v));

    // Backpressure: hold the result for 20 cycles while in_valid toggles.
    start_block(vecs[0].pt, vecs[0].key, acc);
    wait_valid(at);
    for (int i = 0; i < 20; i++) begin
      in_valid  = i[0];
      plaintext = vecs[1].pt;
      key       = vecs[1].key;
      @(negedge clk);
      check("bp ciphertext", ciphertext, vecs[0].ct);
      check("bp {out_valid,in_ready,busy}", {125'b0, out_valid, in_ready, busy}, 128'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release {out_valid,in_ready}", {126'b0, out_valid, in_ready}, 128'b01);
    run_block(vecs[1], "after_bp");

    // Back-to-back with in_valid and out_ready held high.
    j = 0; k = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && k < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        check("b2b ciphertext", ciphertext, vecs[k].ct);
        k++;
      end
      if (j < 3) begin
        in_valid = 1'b1; plaintext = vecs[j].pt; key = vecs[j].key;
      end else begin
        in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        acc3[j] = cyc;
        j++;
      end
    end
    check("b2b results", 128'(k), 128'd3);
    check("b2b spacing 0-1", 128'(acc3[1] - acc3[0]), 128'd12);
    check("b2b spacing 1-2", 128'(acc3[2] - acc3[1]), 128'd12);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // Reset in the middle of a block.
    start_block(vecs[0].pt, vecs[0].key, acc);
    wait_round(4'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-rst {in_ready,out_valid,busy}", {125'b0, in_ready, out_valid, busy}, 128'b100);
    check("mid-rst round_idx", {124'b0, round_idx}, 128'd0);
    check("mid-rst ciphertext", ciphertext, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("mid-rst no out_valid", {127'b0, seen}, 128'd0);
    run_block(vecs[2], "after_rst");

`ifdef AES_ROUND_CONTROLLER_ABORT_EN
    // Abort during round 3.
    start_block(vecs[1].pt, vecs[1].key, acc);
    wait_round(4'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort {in_ready,out_valid,busy}", {125'b0, in_ready, out_valid, busy}, 128'b100);
    check("abort round_idx", {124'b0, round_idx}, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("abort no out_valid", {127'b0, seen}, 128'd0);
    run_block(vecs[0], "after_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
